psum_drain: RTL and testbench
=============================

# psum_drain

Output-side controller for one row of systolic-array PEs. On a start pulse it commands the PEs to expose their accumulated partial sums and snapshots the whole row. It then streams the sums one word at a time over a valid/ready interface to the ofmap buffer, and finally pulses a register clear so the row is ready for the next tile. It drives the PE output-enable and clear controls and consumes the PE ofmap outputs.

## Interface
- DATA_WIDTH, 8, operand width of the PEs; each psum word is 2*DATA_WIDTH bits.
- NUM_PE, 4, number of PEs in the row, ≥ 2; index width IDX_W = $clog2(NUM_PE).
- i_clk  input  1  clock; all logic on rising edge.
- i_nrst  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle request to drain the row, issued after the last MAC cycle.
- i_psum  input  NUM_PE*2*DATA_WIDTH  concatenated PE ofmap outputs; PE k occupies bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH].
- o_psum_out_en  output  1  to all PEs of the row: latch accumulator into the PE output register.
- o_reg_clear  output  1  to all PEs of the row: clear PE registers.
- o_data  output  2*DATA_WIDTH  psum word being offered.
- o_index  output  IDX_W  PE index of o_data.
- o_valid  output  1  o_data/o_index/o_last are valid.
- o_last  output  1  the current word is the final word of the row (index NUM_PE-1).
- i_ready  input  1  downstream accepts the word this cycle.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when the drain completes.

## Operation
- FSM states: IDLE, LATCH, CAPTURE, STREAM, CLEAR.
- IDLE:
  - i_start=1 → LATCH.
  - Otherwise stay in IDLE.
- LATCH (1 cycle): o_psum_out_en=1 → CAPTURE.
- CAPTURE (1 cycle): i_psum is registered into an internal NUM_PE-word snapshot buffer at the end of this cycle; word counter is set to 0 → STREAM.
- STREAM:
  - Outputs: o_valid=1, o_data=buffer[counter], o_index=counter, o_last=(counter==NUM_PE-1).
  - A transfer occurs when o_valid & i_ready.
  - On a transfer with o_last=0, the counter increments.
  - On a transfer with o_last=1 → CLEAR.
  - With i_ready=0, o_data, o_index and o_last hold stable; no word is dropped or repeated.
- CLEAR (1 cycle): o_reg_clear=1 and o_done=1 → IDLE.
- o_psum_out_en and o_reg_clear are never asserted in the same cycle, because the PE gives psum_out_en priority over clear.
- i_start is ignored while o_busy=1; it is not queued.
- Psum words are unsigned and forwarded unmodified. The snapshot decouples the stream from PE activity, so the PEs may begin the next tile's MACs after CLEAR.
- Control outputs (o_psum_out_en, o_reg_clear, o_done, o_valid, o_last, o_busy, o_index) are state-decoded from registered state. There is no combinational path from i_start or i_ready to any output.

## Timing
- Reset values: all outputs 0. State is IDLE, counter is 0, and the snapshot buffer is all zeros.
- Reset asserted mid-drain returns to IDLE immediately. No o_reg_clear or o_done is issued for the aborted drain.
- Sequence with i_start high in cycle 0:
  - Cycle 1: LATCH; o_psum_out_en=1.
  - Cycle 2: CAPTURE; i_psum sampled at the end of the cycle.
  - Cycle 3: first o_valid.
- With i_ready held high, words occupy cycles 3 … 3+NUM_PE-1 and CLEAR/o_done falls in cycle 3+NUM_PE. Total drain is NUM_PE+4 cycles from i_start until IDLE is re-entered.
- Each cycle with i_ready=0 during STREAM adds exactly one cycle.
- i_start arriving in the same cycle as o_done is ignored; it is accepted one cycle later, in IDLE.

## Test plan
- Reset check: hold i_nrst=0 → all outputs 0; release with no stimulus → outputs stay 0 and o_busy=0.
- Basic drain (NUM_PE=4, DATA_WIDTH=8): i_psum words {PE0..PE3}={0x0011,0x0222,0x3333,0xFFFF}, i_start in cycle 0, i_ready=1 → o_psum_out_en in cycle 1; valid words 0x0011,0x0222,0x3333,0xFFFF with index 0..3 in cycles 3–6; o_last only in cycle 6; o_reg_clear and o_done in cycle 7.
- Backpressure: same data, i_ready=0 during cycles 3–5 and cycle 8 → word 0 held stable until cycle 6; every word delivered exactly once, in order; o_done in cycle 11.
- Snapshot isolation: change i_psum to all 0xAAAA from cycle 3 onward → streamed words are still the values sampled in cycle 2.
- Ignored start: pulse i_start during STREAM and again coincident with o_done → no second drain; a start one cycle after o_done produces a full new drain.
- Reset mid-stream: assert i_nrst=0 while word 1 is pending → outputs 0 at once, no o_reg_clear pulse; the next i_start performs a complete drain.

Source files
------------

// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
//
// Output-side drain controller for one row of systolic-array PEs. A start
// pulse asks the PEs to expose their accumulated partial sums, the whole row
// is snapshotted into a local buffer, the words are streamed one per transfer
// over a valid/ready interface, and finally the PE registers are cleared so
// the row can begin its next tile.
//
// Ports
//   i_clk          clock, rising edge
//   i_nrst         asynchronous active-low reset
//   i_start        one-cycle drain request (ignored while busy)
//   i_psum         concatenated PE outputs, PE k at [k*2*DATA_WIDTH +: 2*DATA_WIDTH]
//   o_psum_out_en  to PEs: latch accumulator into PE output register
//   o_reg_clear    to PEs: clear PE registers
//   o_data         psum word offered downstream
//   o_index        PE index of o_data
//   o_valid        o_data / o_index / o_last are valid
//   o_last         current word is the final one of the row
//   i_ready        downstream accepts the word this cycle
//   o_busy         controller is not idle
//   o_done         one-cycle pulse when the drain completes
// -----------------------------------------------------------------------------
module psum_drain #(
   parameter int  DATA_WIDTH = 8,
   parameter int  NUM_PE     = 4,
   localparam int IDX_W      = $clog2(NUM_PE),
   localparam int PSUM_W     = 2 * DATA_WIDTH
) (
   input  logic                     i_clk,
   input  logic                     i_nrst,
   input  logic                     i_start,
   input  logic [NUM_PE*PSUM_W-1:0] i_psum,
   output logic                     o_psum_out_en,
   output logic                     o_reg_clear,
   output logic [PSUM_W-1:0]        o_data,
   output logic [IDX_W-1:0]         o_index,
   output logic                     o_valid,
   output logic                     o_last,
   input  logic                     i_ready,
   output logic                     o_busy,
   output logic                     o_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_CAPTURE,
      S_STREAM,
      S_CLEAR
   } state_t;

   state_t                          state_q, state_d;
   logic [IDX_W-1:0]                cnt_q, cnt_d;
   logic [NUM_PE-1:0][PSUM_W-1:0]   snap_q, snap_d;
   logic                            capture_en;
   logic                            last_word;

   assign last_word = (cnt_q == IDX_W'(NUM_PE - 1));

   // Next-state and state-decoded outputs. Every output depends only on
   // state_q / cnt_q / snap_q, so i_start and i_ready never reach an output
   // combinationally.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      capture_en    = 1'b0;
      o_psum_out_en = 1'b0;
      o_reg_clear   = 1'b0;
      o_done        = 1'b0;
      o_valid       = 1'b0;
      o_last        = 1'b0;
      o_index       = '0;
      o_data        = '0;
      o_busy        = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            o_psum_out_en = 1'b1;
            state_d       = S_CAPTURE;
         end
         S_CAPTURE: begin
            // PE output registers are now stable; take the snapshot so the
            // stream no longer depends on what the PEs do next.
            capture_en = 1'b1;
            cnt_d      = '0;
            state_d    = S_STREAM;
         end
         S_STREAM: begin
            o_valid = 1'b1;
            o_data  = snap_q[cnt_q];
            o_index = cnt_q;
            o_last  = last_word;
            if (i_ready) begin
               if (last_word) begin
                  state_d = S_CLEAR;
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
            end
         end
         S_CLEAR: begin
            o_reg_clear = 1'b1;
            o_done      = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign snap_d = capture_en ? i_psum : snap_q;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
      end
   end

endmodule

// File: tb/tb_psum_drain.sv
// -----------------------------------------------------------------------------
// tb_psum_drain
//
// Scoreboard bench for psum_drain (DATA_WIDTH=8, NUM_PE=4). Stimulus pushes
// the expected words (with their transfer cycle) and the expected control
// pulse cycles into queues; a monitor on the falling edge pops and compares
// whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_psum_drain;

   localparam int DW    = 8;
   localparam int NPE   = 4;
   localparam int PW    = 2 * DW;
   localparam int IW    = 2;

   logic                 clk;
   logic                 nrst;
   logic                 start;
   logic [NPE*PW-1:0]    psum;
   logic                 psum_out_en;
   logic                 reg_clear;
   logic [PW-1:0]        data;
   logic [IW-1:0]        index;
   logic                 valid;
   logic                 last;
   logic                 ready;
   logic                 busy;
   logic                 done;

   psum_drain #(.DATA_WIDTH(DW), .NUM_PE(NPE)) dut (
      .i_clk         (clk),
      .i_nrst        (nrst),
      .i_start       (start),
      .i_psum        (psum),
      .o_psum_out_en (psum_out_en),
      .o_reg_clear   (reg_clear),
      .o_data        (data),
      .o_index       (index),
      .o_valid       (valid),
      .o_last        (last),
      .i_ready       (ready),
      .o_busy        (busy),
      .o_done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [PW-1:0] data;
      logic [IW-1:0] idx;
      logic          last;
      int            cyc;
   } word_t;

   word_t exp_q[$];
   int    en_q[$];
   int    done_q[$];

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {8'h0, psum_out_en, reg_clear, data, index, valid, last, busy, done};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (nrst) begin
         if (valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", {index, data}, 32'h0);
               chk("unexpected_word_valid", 32'(valid), 32'h0);
            end else begin
               word_t w;
               w = exp_q[0];
               chk("word_data",  32'(data),  32'(w.data));
               chk("word_index", 32'(index), 32'(w.idx));
               chk("word_last",  32'(last),  32'(w.last));
               if (ready) begin
                  chk("word_cycle", 32'(cyc), 32'(w.cyc));
                  $display("word idx=%0d data=0x%04h last=%0d cyc=%0d", index, data, last, cyc);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (psum_out_en) begin
            if (en_q.size() == 0) chk("unexpected_psum_out_en", 32'(psum_out_en), 32'h0);
            else chk("psum_out_en_cycle", 32'(cyc), 32'(en_q.pop_front()));
         end
         if (done) begin
            if (done_q.size() == 0) chk("unexpected_done", 32'(done), 32'h0);
            else begin
               $display("done cyc=%0d", cyc);
               chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
            end
         end
         if (reg_clear != done) chk("clear_eq_done", 32'(reg_clear), 32'(done));
         if (psum_out_en && reg_clear) chk("en_clear_overlap", 32'h1, 32'h0);
      end
   end

   // ---------------- stimulus ----------------
   // Called just after a rising edge; applies one full drain. stall_mask bit r
   // drops i_ready in the cycle r after the start cycle. Optionally corrupts
   // i_psum once it has been sampled, and pokes i_start while busy and again
   // in the o_done cycle. Returns just after the edge following o_done.
   task automatic run_drain(input logic [NPE*PW-1:0] p, input logic [31:0] stall_mask,
                            input bit corrupt, input bit poke);
      int t0;
      int r;
      int done_rel;
      t0 = cyc;
      en_q.push_back(t0 + 1);
      r = 3;
      for (int w = 0; w < NPE; w++) begin
         word_t e;
         while (r < 31 && stall_mask[r]) r++;
         e.data = p[w*PW +: PW];
         e.idx  = IW'(w);
         e.last = (w == NPE - 1);
         e.cyc  = t0 + r;
         exp_q.push_back(e);
         r++;
      end
      done_rel = r;
      done_q.push_back(t0 + done_rel);
      $display("drain start cyc=%0d stall=0x%08h corrupt=%0d poke=%0d", t0, stall_mask, corrupt, poke);
      psum = p;
      for (int rel = 0; rel <= done_rel; rel++) begin
         start = (rel == 0) || (poke && (rel == 4 || rel == done_rel));
         ready = (rel < 32) ? !stall_mask[rel] : 1'b1;
         if (corrupt && rel >= 3) psum = {NPE{16'hAAAA}};
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      ready = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   localparam logic [NPE*PW-1:0] BASIC = {16'hFFFF, 16'h3333, 16'h0222, 16'h0011};
   localparam logic [NPE*PW-1:0] ALT   = {16'h8001, 16'h1234, 16'hBEEF, 16'h5A5A};
   localparam logic [NPE*PW-1:0] ALT2  = {16'h0F0F, 16'h7777, 16'h0001, 16'hC3C3};

   initial begin
      nrst  = 1'b0;
      start = 1'b0;
      ready = 1'b1;
      psum  = BASIC;

      // reset held
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_outs", all_outs(), 32'h0);
      end
      @(posedge clk);
      #1;
      nrst = 1'b1;
      // released with no stimulus
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_outs", all_outs(), 32'h0);
      end
      @(posedge clk);
      #1;

      // basic drain
      run_drain(BASIC, 32'h0, 1'b0, 1'b0);
      idle(2);
      // backpressure: ready low in cycles 3,4,5 and 8
      run_drain(BASIC, 32'h0000_0138, 1'b0, 1'b0);
      idle(2);
      // snapshot isolation
      run_drain(ALT, 32'h0000_0040, 1'b1, 1'b0);
      idle(1);
      // ignored starts, then a start one cycle after o_done
      run_drain(ALT2, 32'h0, 1'b0, 1'b1);
      run_drain(BASIC, 32'h0, 1'b0, 1'b0);
      idle(2);

      // reset while word 1 is pending
      begin
         int t0;
         word_t e;
         t0 = cyc;
         en_q.push_back(t0 + 1);
         e.data = ALT[0 +: PW];
         e.idx  = '0;
         e.last = 1'b0;
         e.cyc  = t0 + 3;
         exp_q.push_back(e);
         $display("drain start cyc=%0d with reset at word 1", t0);
         psum = ALT;
         for (int rel = 0; rel < 4; rel++) begin
            start = (rel == 0);
            ready = 1'b1;
            @(posedge clk);
            #1;
         end
         ready = 1'b0;
         #1;
         nrst = 1'b0;
         #1;
         chk("reset_mid_outs", all_outs(), 32'h0);
         idle(2);
         nrst  = 1'b1;
         ready = 1'b1;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_abort_outs", all_outs(), 32'h0);
         end
         @(posedge clk);
         #1;
      end
      run_drain(ALT2, 32'h0000_0010, 1'b0, 1'b0);
      idle(3);

      chk("words_left",  32'(exp_q.size()),  32'h0);
      chk("en_left",     32'(en_q.size()),   32'h0);
      chk("done_left",   32'(done_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
